div_unit: RTL and testbench

Parametrised iterative integer divider for the EXE stage. It replaces the two vendor divider instances (signed and unsigned) with one unit that covers both. The unit accepts one operation per request through a valid/ready handshake and returns a quotient or remainder with a tag through a second valid/ready handshake. It runs WIDTH/BITS_PER_CYCLE iterations per operation and supports pipeline flush.

---
 rtl/div_pkg.sv | 26 ++
 rtl/div_step.sv | 41 ++++
 rtl/div_unit.sv | 194 +++++++++++++++++++
 tb/tb_div_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: op encodings, FSM states
// and small op-decode helpers.
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_MOD  = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_MODU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Signed ops treat operands as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Remainder-returning ops.
  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_MOD) || (op == OP_MODU);
  endfunction

endpackage

// File: rtl/div_step.sv
// Combinational restoring-division slice: performs BITS_PER_CYCLE
// shift/compare/subtract steps on a {remainder, quotient} pair.
// Ports:
//   rem_i/quo_i     current partial remainder and dividend/quotient shifter
//   divisor_i       divisor magnitude
//   rem_o/quo_o     values after BITS_PER_CYCLE steps
module div_step #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   trial;

  // Trial is one bit wider: the shifted remainder can exceed WIDTH bits
  // before the subtract brings it back below the divisor.
  always_comb begin
    rem   = rem_i;
    quo   = quo_i;
    trial = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      trial = {rem, quo[WIDTH-1]};
      quo   = {quo[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, divisor_i}) begin
        trial  = trial - {1'b0, divisor_i};
        quo[0] = 1'b1;
      end
      rem = trial[WIDTH-1:0];
    end
    rem_o = rem;
    quo_o = quo;
  end

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned integer divider for the EXE stage.
// One request in via in_valid/in_ready, one quotient or remainder out via
// out_valid/out_ready, WIDTH/BITS_PER_CYCLE iterations per operation.
// Ports:
//   clk, reset (sync, active-high), flush (abort in-flight op)
//   in_valid/in_ready, in_op, in_src1 (dividend), in_src2 (divisor), in_tag
//   out_valid/out_ready, out_result, out_tag
//   busy (state not IDLE)
// Build option: DIV_ZERO_FAST_EN -- a divide-by-zero request bypasses the
// iteration phase and is presented in the cycle after acceptance.
import div_pkg::*;

module div_unit #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned TAG_W          = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(N + 1);

  if ((WIDTH % 2) != 0 || (WIDTH % BITS_PER_CYCLE) != 0 ||
      !((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) || (BITS_PER_CYCLE == 4)))
  begin : g_param_err
    $error("div_unit: illegal WIDTH/BITS_PER_CYCLE combination");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] otag_q, otag_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] q_fix, r_fix, fin_result;
  logic             accept;
  logic             src1_neg, src2_neg;
  logic [WIDTH-1:0] src1_mag, src2_mag;

  div_step #(
    .WIDTH         (WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  // Handshake decodes: registered state gated only by flush/out_ready.
  assign in_ready  = ((state_q == IDLE) || ((state_q == DONE) && out_ready)) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_result = result_q;
  assign out_tag    = otag_q;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // its correct unsigned magnitude.
  assign src1_neg = op_is_signed(in_op) && in_src1[WIDTH-1];
  assign src2_neg = op_is_signed(in_op) && in_src2[WIDTH-1];
  assign src1_mag = src1_neg ? -in_src1 : in_src1;
  assign src2_mag = src2_neg ? -in_src2 : in_src2;

  // Final sign correction and divide-by-zero override, taken from the
  // last step's outputs.
  assign q_fix = qneg_q ? -step_quo : step_quo;
  assign r_fix = rneg_q ? -step_rem : step_rem;
  always_comb begin
    if (dz_q) fin_result = op_is_rem(op_q) ? src1_q : '1;
    else      fin_result = op_is_rem(op_q) ? r_fix : q_fix;
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    src1_d   = src1_q;
    result_d = result_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    op_d     = op_q;
    tag_d    = tag_q;
    otag_d   = otag_q;

    case (state_q)
      IDLE: ;
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = fin_result;
          otag_d   = tag_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accept may overlap a drain in DONE; it overrides the IDLE transition.
    if (accept) begin
      rem_d   = '0;
      quo_d   = src1_mag;
      dvs_d   = src2_mag;
      src1_d  = in_src1;
      qneg_d  = src1_neg ^ src2_neg;
      rneg_d  = src1_neg;
      dz_d    = (in_src2 == '0);
      op_d    = in_op;
      tag_d   = in_tag;
      cnt_d   = CNT_W'(N);
      state_d = CALC;
`ifdef DIV_ZERO_FAST_EN
      if (in_src2 == '0) begin
        result_d = op_is_rem(in_op) ? in_src1 : '1;
        otag_d   = in_tag;
        cnt_d    = '0;
        state_d  = DONE;
      end
`endif
    end

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      src1_q   <= '0;
      result_q <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      op_q     <= '0;
      tag_q    <= '0;
      otag_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      src1_q   <= src1_d;
      result_q <= result_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      otag_q   <= otag_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (default parameters): directed vectors
// with literal expectations plus a queue-based arithmetic model compared
// on every cycle.
import div_pkg::*;

module tb_div_unit;

  localparam int NIT = 32;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 0;  // valid in the cycle right after the accept edge
`else
  localparam int ZLAT = NIT;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]  in_op;
  logic [31:0] in_src1, in_src2, out_result;
  logic [4:0]  in_tag, out_tag;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  div_unit dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Arithmetic reference: plain 64-bit integer division, truncating toward
  // zero, with the divide-by-zero convention applied first.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return (op == OP_MOD || op == OP_MODU) ? a : 32'hFFFF_FFFF;
    if (op == OP_DIVU || op == OP_MODU) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    q = sa / sb;
    r = sa % sb;
    return (op == OP_MOD || op == OP_MODU) ? r[31:0] : q[31:0];
  endfunction

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          due;
  } exp_t;
  exp_t sb[$];

  // Scoreboard compare: outputs checked every cycle against the model queue.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (sb.size() == 0) begin
        chk("idle_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("valid_timing", 32'(out_valid), 32'(cyc >= sb[0].due));
        if (out_valid) begin
          chk("model_result", out_result, sb[0].res);
          chk("model_tag", 32'(out_tag), 32'(sb[0].tag));
        end
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
        if (in_valid && in_ready)
          sb.push_back('{model(in_op, in_src1, in_src2), in_tag,
                         cyc + 1 + ((in_src2 == 32'd0) ? ZLAT : NIT)});
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    bit got = 1'b0;
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) timeout_fail("accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge; counts edges until out_valid.
  task automatic wait_result(input logic [31:0] exp, input logic [4:0] tag,
                             input int lat, input string name);
    bit got = 1'b0;
    int k = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
      k++;
    end
    if (!got) timeout_fail(name);
    else begin
      chk(name, out_result, exp);
      chk({name, "_tag"}, 32'(out_tag), 32'(tag));
      chk({name, "_lat"}, 32'(k), 32'(lat));
    end
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[19];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD},
      '{OP_MOD,  32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF},
      '{OP_DIVU, 32'hFFFF_FFF9, 32'd2,         5'd1,  32'h7FFF_FFFC},
      '{OP_MODU, 32'hFFFF_FFF9, 32'd2,         5'd2,  32'h0000_0001},
      '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd3,  32'h8000_0000},
      '{OP_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 5'd4,  32'h0000_0000},
      '{OP_DIV,  32'd100,       32'd0,         5'd5,  32'hFFFF_FFFF},
      '{OP_MOD,  32'd100,       32'd0,         5'd6,  32'd100},
      '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 5'd8,  32'hFFFF_FFFD},
      '{OP_MOD,  32'd7,         32'hFFFF_FFFE, 5'd9,  32'h0000_0001},
      '{OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd10, 32'h0000_0003},
      '{OP_MOD,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFF},
      '{OP_MODU, 32'd5,         32'd0,         5'd12, 32'd5},
      '{OP_DIVU, 32'hFFFF_FFFF, 32'd1,         5'd13, 32'hFFFF_FFFF},
      '{OP_DIV,  32'h8000_0000, 32'd0,         5'd14, 32'hFFFF_FFFF},
      '{OP_MOD,  32'h8000_0000, 32'd0,         5'd15, 32'h8000_0000},
      '{OP_DIVU, 32'd0,         32'd5,         5'd16, 32'd0},
      '{OP_DIV,  32'h8000_0000, 32'd2,         5'd17, 32'hC000_0000},
      '{OP_MODU, 32'h8000_0000, 32'd3,         5'd18, 32'd2}
    };

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = OP_DIV; in_src1 = '0; in_src2 = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed vectors with literal results.
    for (int i = 0; i < 19; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_result(vecs[i].exp, vecs[i].tag, (vecs[i].b == 32'd0) ? ZLAT : NIT,
                  $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 cycles, then drain and accept together.
    out_ready = 1'b0;
    issue(OP_DIVU, 32'd1000, 32'd7, 5'd3);
    wait_result(32'd142, 5'd3, NIT, "bp_first");
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", out_result, 32'd142);
      chk("bp_hold_tag", 32'(out_tag), 32'd3);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = OP_MODU; in_src1 = 32'd1000; in_src2 = 32'd7; in_tag = 5'd4;
    @(negedge clk);
    chk("bp_overlap_in_ready", 32'(in_ready), 32'd1);
    chk("bp_overlap_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(32'd6, 5'd4, NIT, "bp_second");

    // flush beats in_valid in IDLE.
    flush = 1'b1; in_valid = 1'b1; in_op = OP_DIV; in_src1 = 32'd9; in_src2 = 32'd3;
    @(negedge clk);
    chk("flush_blocks_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_blocks_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // flush in the 10th CALC cycle.
    issue(OP_DIV, 32'd12345, 32'd67, 5'd9);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    issue(OP_DIVU, 32'd1000, 32'd7, 5'd21);
    wait_result(32'd142, 5'd21, NIT, "post_flush");

    // Same sequence with reset mid-CALC.
    issue(OP_DIV, 32'd12345, 32'd67, 5'd9);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_result", out_result, 32'd0);
    chk("midrst_out_tag", 32'(out_tag), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    issue(OP_DIVU, 32'd1000, 32'd7, 5'd22);
    wait_result(32'd142, 5'd22, NIT, "post_reset");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
